dsp_p_quantizer: RTL and testbench

Downstream consumer of the DSP48A1 slice's 48-bit P output. Each valid P sample is rounded, right-shifted and saturated to a narrow signed word, then buffered in a small first-word-fall-through FIFO with a valid/ready output handshake. It decouples the free-running DSP pipeline from a back-pressuring sink, and records saturation and drop events in sticky flags.

---
 rtl/dsp_p_quantizer.sv | 146 ++++++++++++++
 tb/tb_dsp_p_quantizer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_p_quantizer.sv
// Rounds, shifts and saturates the DSP48A1 P output to a narrow signed word,
// then buffers it in a small FWFT FIFO with a valid/ready output handshake.
module dsp_p_quantizer #(
    parameter int SHIFT = 17,
    parameter int OUT_W = 18,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [47:0]              p_in,
    input  logic                     p_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     sat_flag,
    output logic                     drop_flag,
    input  logic                     sat_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic signed [48:0] RND =
        (SHIFT == 0) ? 49'sd0 : (49'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0));
    localparam logic signed [48:0] SAT_MAX = (49'sd1 <<< (OUT_W - 1)) - 49'sd1;
    localparam logic signed [48:0] SAT_MIN = -(49'sd1 <<< (OUT_W - 1));

    // Stage 1: round-half-up in 49 bits so the rounding add cannot overflow.
    logic signed [48:0] p_ext;
    logic signed [48:0] rnd_sum;
    logic signed [48:0] r1;
    logic               v1;

    assign p_ext   = {p_in[47], p_in};
    assign rnd_sum = p_ext + RND;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            r1 <= '0;
        end else begin
            v1 <= p_valid;
            r1 <= rnd_sum >>> SHIFT;
        end
    end

    // Stage 2: clamp into the signed OUT_W range.
    logic             over;
    logic             under;
    logic [OUT_W-1:0] sat_val;
    logic [OUT_W-1:0] d2;
    logic             v2;
    logic             sat_set;

    always_comb begin
        over    = (r1 > SAT_MAX);
        under   = (r1 < SAT_MIN);
        sat_val = r1[OUT_W-1:0];
        if (over) begin
            sat_val = SAT_MAX[OUT_W-1:0];
        end else if (under) begin
            sat_val = SAT_MIN[OUT_W-1:0];
        end
        sat_set = v1 && (over || under);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            d2 <= '0;
        end else begin
            v2 <= v1;
            d2 <= sat_val;
        end
    end

    // Output handshake: a word transfers on any rising edge where out_valid and
    // out_ready are both 1; out_valid/out_data are registered and never depend
    // combinationally on out_ready, and out_data holds while out_valid && !out_ready.
    logic [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    count_next;
    logic [OUT_W-1:0] head_next;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop_set;

    always_comb begin
        full     = (count == CW'(DEPTH));
        pop      = out_valid && out_ready;
        push     = v2 && (!full || pop);
        drop_set = v2 && full && !pop;
        rd_next  = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
        // The new head is the word being written when it lands in the read slot.
        head_next = mem[rd_next];
        if (push && (rd_next == wr_ptr)) begin
            head_next = d2;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= d2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr    <= rd_next;
            count     <= count_next;
            out_valid <= (count_next != '0);
            out_data  <= head_next;
        end
    end

    // Sticky flags: a set event in the same cycle as sat_clr wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag  <= 1'b0;
            drop_flag <= 1'b0;
        end else begin
            sat_flag  <= sat_set  || (sat_flag  && !sat_clr);
            drop_flag <= drop_set || (drop_flag && !sat_clr);
        end
    end

endmodule

// File: tb/tb_dsp_p_quantizer.sv
// Self-checking bench for dsp_p_quantizer: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_dsp_p_quantizer;

    localparam int SHIFT = 4;
    localparam int OUT_W = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [47:0]      p_in = '0;
    logic             p_valid = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CW-1:0]    count;
    logic             sat_flag;
    logic             drop_flag;
    logic             sat_clr = 1'b0;

    // Clock/reset block
    always #5 clk = ~clk;

    dsp_p_quantizer #(.SHIFT(SHIFT), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .sat_flag(sat_flag), .drop_flag(drop_flag),
        .sat_clr(sat_clr)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;
    logic [OUT_W-1:0] popped[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] w(input int v);
        return v[OUT_W-1:0];
    endfunction

    // Reference arithmetic: round-half-up, arithmetic shift, clamp.
    function automatic logic [OUT_W-1:0] quant(input logic [47:0] p, output bit sat);
        longint v, hi, lo;
        v = longint'($signed(p));
        if (SHIFT > 0) v = v + (longint'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0));
        v = v >>> SHIFT;
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -(longint'(1) <<< (OUT_W - 1));
        sat = (v > hi) || (v < lo);
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v[OUT_W-1:0];
    endfunction

    // Scoreboard model: two-edge delay line feeding an expected queue.
    logic [OUT_W-1:0] exp_q[$];
    bit               m_sat = 1'b0;
    bit               m_drop = 1'b0;
    bit               pv0 = 1'b0;
    bit               pv1 = 1'b0;
    logic [47:0]      p0 = '0;
    logic [47:0]      p1 = '0;

    always @(posedge clk or posedge rst) begin : model
        bit do_pop, do_push, s0, s1;
        logic [OUT_W-1:0] q0, q1;
        if (rst) begin
            exp_q.delete();
            m_sat = 1'b0; m_drop = 1'b0;
            pv0 = 1'b0; pv1 = 1'b0;
        end else begin
            do_pop  = (exp_q.size() > 0) && out_ready;
            do_push = pv1 && ((exp_q.size() < DEPTH) || do_pop);
            q1 = quant(p1, s1);
            q0 = quant(p0, s0);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(q1);
            m_sat  = (pv0 && s0) || (m_sat && !sat_clr);
            m_drop = (pv1 && !do_push) || (m_drop && !sat_clr);
            pv1 = pv0; p1 = p0;
            pv0 = p_valid; p0 = p_in;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (check_en && !rst) begin
            check("m_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            check("m_count", 32'(count), 32'(exp_q.size()));
            if (exp_q.size() > 0) check("m_data", 32'(out_data), 32'(exp_q[0]));
            check("m_sat", 32'(sat_flag), 32'(m_sat));
            check("m_drop", 32'(drop_flag), 32'(m_drop));
            if (out_valid && out_ready) popped.push_back(out_data);
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic drive(input bit v, input longint p, input bit rdy, input bit clr);
        p_valid   = v;
        p_in      = p[47:0];
        out_ready = rdy;
        sat_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid();
        p_valid = 1'b0;
        sat_clr = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_sat", 32'(sat_flag), 32'd0);
        check("rst_drop", 32'(drop_flag), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_popped(input string nm, input int vals[], input int n);
        check({nm, "_len"}, 32'(popped.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < popped.size()) check(nm, 32'(popped[i]), 32'(w(vals[i])));
        end
    endtask

    initial begin
        int exp1[];
        longint p;

        @(posedge clk); #1;
        drive(0, 0, 0, 0);
        reset_mid();
        check_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0);
            check("idle_valid", 32'(out_valid), 32'd0);
        end

        // Rounding and latency
        popped.delete();
        drive(1, 37, 1, 0);
        drive(1, 40, 1, 0);
        check("lat_early", 32'(out_valid), 32'd0);
        drive(1, -40, 1, 0);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data", 32'(out_data), 32'(w(2)));
        drive(1, 0, 1, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
        exp1 = '{2, 3, -2, 0};
        check_popped("round", exp1, 4);
        check("round_sat", 32'(sat_flag), 32'd0);

        // Saturation and sticky clear
        popped.delete();
        drive(1, 5000, 1, 0);
        drive(1, -5000, 1, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
        exp1 = '{127, -128};
        check_popped("sat", exp1, 2);
        check("sat_set", 32'(sat_flag), 32'd1);
        drive(0, 0, 1, 1);
        check("sat_clr", 32'(sat_flag), 32'd0);
        drive(1, 5000, 1, 0);
        drive(0, 0, 1, 1);
        check("sat_clr_race", 32'(sat_flag), 32'd1);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0);
        drive(0, 0, 1, 1);

        // Full and drop
        for (int i = 0; i < 6; i++) drive(1, 16 * (i + 1), 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("full_count", 32'(count), 32'd4);
        check("full_drop", 32'(drop_flag), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_data", 32'(out_data), 32'(w(i + 1)));
            drive(0, 0, 1, 0);
        end
        check("drain_empty", 32'(out_valid), 32'd0);
        check("drain_count", 32'(count), 32'd0);
        drive(0, 0, 1, 1);

        // Simultaneous push/pop at full, across the pointer wrap
        popped.delete();
        for (int i = 0; i < 10; i++) begin
            drive(i < 8, 16 * (i + 1), i >= 6, 0);
            if (i >= 5) check("pp_count", 32'(count), 32'd4);
        end
        check("pp_drop", 32'(drop_flag), 32'd0);
        for (int i = 0; i < 6; i++) drive(0, 0, 1, 0);
        exp1 = '{1, 2, 3, 4, 5, 6, 7, 8};
        check_popped("pp_order", exp1, 8);

        // Reset while busy: 3 stored, 2 in flight
        for (int i = 0; i < 5; i++) drive(1, 16 * (i + 1), 0, 0);
        check("busy_count", 32'(count), 32'd3);
        reset_mid();
        popped.delete();
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
        check("post_rst_none", 32'(popped.size()), 32'd0);
        check("post_rst_count", 32'(count), 32'd0);
        drive(1, 160, 1, 0);
        drive(0, 0, 1, 0);
        check("fresh_early", 32'(out_valid), 32'd0);
        drive(0, 0, 1, 0);
        check("fresh_valid", 32'(out_valid), 32'd1);
        check("fresh_data", 32'(out_data), 32'(w(10)));
        drive(0, 0, 1, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: p = longint'($urandom_range(0, 8191)) - 4096;
                1: p = longint'($urandom_range(0, 255)) * 16 + 8 - 2048;
                2: p = {$urandom, $urandom};
                default: begin
                    p = longint'($urandom_range(1900, 2200));
                    if ($urandom_range(0, 1) == 1) p = -p;
                end
            endcase
            drive($urandom_range(0, 3) != 0, p, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 8; i++) drive(0, 0, 1, 0);
        check("final_empty", 32'(count), 32'd0);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
